sdfm_result_fifo: RTL and testbench
===================================

Name: sdfm_result_fifo

Overview:
- Parametrised N-channel result collector for the sigma-delta filter module.
- Takes per-channel filter update pulses and 32-bit results, arbitrates them round-robin, and tags each with its channel index into one shared FIFO.
- The CPU drains the FIFO through the register map; the block raises level-up and per-channel overrun events for the IRQ logic.
- Replaces per-channel private FIFOs when channel count exceeds 2.

Parameters:
CH_NUM, 4, number of filter channels (1..16)
DATA_W, 32, filter result width
DEPTH, 16, shared FIFO entries; power of 2, 2..256
TAG_W, max(1,clog2(CH_NUM)), channel tag width (derived, not overridden)
CNT_W, clog2(DEPTH)+1, fill-count width (derived)

Ports:
SYSCLK  in  1  system clock, all logic on rising edge
SYSRSTn  in  1  asynchronous active-low reset
en_reg  in  1  block enable; 0 acts as continuous flush
ch_en_regx  in  CH_NUM  per-channel capture enable
update_signalx  in  CH_NUM  one-cycle result-valid pulses from the channel filters
data_inx  in  CH_NUM*DATA_W  channel results; channel i in [DATA_W*(i+1)-1 : DATA_W*i]
flush_signal  in  1  one-cycle synchronous flush pulse
rd_signal  in  1  one-cycle pop pulse (register-map read of FDATA)
level_reg  in  CNT_W  level-up threshold; 0 disables level-up events
rd_data  out  DATA_W  head-entry data (first-word fall-through)
rd_tag  out  TAG_W  head-entry channel index
count  out  CNT_W  current fill, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
levelup_signal  out  1  one-cycle pulse on crossing the threshold
overrun_signalx  out  CH_NUM  one-cycle pulse per lost channel sample

Behaviour:
- Reset (SYSRSTn=0): pointers, count, pending flags and RR pointer are 0. empty=1, full=0. rd_data=0, rd_tag=0. levelup_signal=0, overrun_signalx=0.
- Capture stage:
  - Each channel has a 1-entry holding register and a pending flag.
  - On the SYSCLK edge where update_signalx[i] & ch_en_regx[i] & en_reg: hold[i] <= data, pending[i] <= 1.
  - If pending[i] was already set and is not granted that cycle: hold is overwritten with the newest data and overrun_signalx[i] pulses on the next cycle.
  - If channel i is granted in the same cycle as a new update: the old value goes to the FIFO, the new value is held, and there is no overrun.
- Arbiter:
  - Combinational round-robin over pending[], starting at rr_ptr.
  - At most one grant per cycle.
  - Grant allowed when count<DEPTH, or when count==DEPTH and rd_signal is active in the same cycle.
  - On grant to channel g: {g, hold[g]} is written at mem[wptr], pending[g] is cleared, and rr_ptr <= (g+1) mod CH_NUM.
  - With no grant, rr_ptr holds.
- Latency: update pulse at edge t → pending after t → FIFO write at edge t+1 → empty=0 and rd_data valid after t+1. That is 2 cycles with no contention. Worst case under contention is CH_NUM+1 cycles while the FIFO has space.
- Pop:
  - rd_signal with count>0 advances rptr.
  - rd_signal while empty is ignored; count stays 0 and there is no error.
  - rd_data/rd_tag always show mem[rptr]. They are undefined-but-stable while empty.
  - Simultaneous push and pop leaves count unchanged.
- FIFO full: pending entries wait in their holding registers. Further updates on those channels produce overruns. FIFO contents are never overwritten.
- Pointers are clog2(DEPTH) bits and wrap naturally. count is tracked separately; it is not derived from the pointers.
- levelup_signal: pulses for one cycle when count_next >= level_reg and count < level_reg, with level_reg != 0. It does not re-fire until count drops below level_reg.
- flush_signal, or en_reg=0:
  - Next edge clears pointers, count and all pending flags, and resets rr_ptr to 0.
  - A grant or update in the same cycle is discarded.
  - overrun_signalx and levelup_signal are suppressed.
- ch_en_regx[i] deasserted: new captures on that channel are blocked, but an already-pending entry is still delivered.
- Asynchronous reset mid-operation: everything returns to reset values immediately. Contents are lost.

Decomposition:
- sdfm_pkg:
  - clog2 function.
  - Constants SDFM_DATA_W=32 and SDFM_MAX_CH=16.
  - Packed entry layout {tag, data}.
- Sub-module sdfm_rr_arb:
  - Parameter N.
  - Inputs: req[N], ptr, allow.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate-priority-rotate.
  - rr_ptr register stays in sdfm_result_fifo.
- Storage: plain register array, no RAM macro.

Test Plan:
- Single update: ch2 pulses data 0x12345678 at t → empty=0 at t+2, rd_tag=2, rd_data=0x12345678, count=1. One rd_signal → empty=1.
- Simultaneous contention: all 4 channels pulse in one cycle (data 0xA0..0xA3), rr_ptr=0 → FIFO order tags 0,1,2,3, written on 4 consecutive edges, count=4. Repeat with rr_ptr=2 → order 2,3,0,1.
- Full/overrun (DEPTH=16):
  - Fill to 16, then ch1 pulses 0x1, then 0x2 → overrun_signalx[1] pulses once, full=1, count=16.
  - One pop → the next entry written is tag 1, data 0x2.
- Push-pop same cycle at count=16: rd_signal plus pending ch0 → count stays 16 and the head advances.
- Level-up: level_reg=4; push 4 entries → levelup_signal pulses exactly at the 3→4 transition. Pop to 3 and push to 4 → pulses again. With level_reg=0 → never pulses.
- Flush and reset: with count=5 and 2 pending, flush_signal → count=0, empty=1, no later writes. Assert SYSRSTn low mid-burst → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sdfm_pkg.sv
// Purpose: shared constants, entry layout and width helpers for the SDFM result collector.
// Latency: none (declarations only).
// Backpressure: n/a.
package sdfm_pkg;

    localparam int SDFM_DATA_W    = 32;
    localparam int SDFM_MAX_CH    = 16;
    localparam int SDFM_TAG_MAX_W = 4;

    // Entry layout for the widest configuration: channel tag above the result.
    typedef struct packed {
        logic [SDFM_TAG_MAX_W-1:0] tag;
        logic [SDFM_DATA_W-1:0]    data;
    } sdfm_entry_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel tag width never drops below one bit.
    function automatic int tag_width(input int ch_num);
        return (ch_num > 1) ? clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/sdfm_result_fifo_if.sv
// Purpose: bundles the filter-side capture inputs, register-map controls and FIFO status outputs.
// Latency: none (wiring only).
// Backpressure: none; overflow is reported through overrun_signalx rather than stalling channels.
// Ports: master = filters/register map/IRQ side, slave = sdfm_result_fifo.
interface sdfm_result_fifo_if #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int TAG_W = sdfm_pkg::tag_width(CH_NUM);
    localparam int CNT_W = sdfm_pkg::clog2(DEPTH) + 1;

    logic                     en_reg;
    logic [CH_NUM-1:0]        ch_en_regx;
    logic [CH_NUM-1:0]        update_signalx;
    logic [CH_NUM*DATA_W-1:0] data_inx;
    logic                     flush_signal;
    logic                     rd_signal;
    logic [CNT_W-1:0]         level_reg;
    logic [DATA_W-1:0]        rd_data;
    logic [TAG_W-1:0]         rd_tag;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic                     full;
    logic                     levelup_signal;
    logic [CH_NUM-1:0]        overrun_signalx;

    modport master (
        output en_reg, ch_en_regx, update_signalx, data_inx, flush_signal, rd_signal, level_reg,
        input  rd_data, rd_tag, count, empty, full, levelup_signal, overrun_signalx
    );

    modport slave (
        input  en_reg, ch_en_regx, update_signalx, data_inx, flush_signal, rd_signal, level_reg,
        output rd_data, rd_tag, count, empty, full, levelup_signal, overrun_signalx
    );

endinterface

// File: rtl/sdfm_rr_arb.sv
// Purpose: combinational round-robin arbiter, lowest index at or after ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: allow=0 suppresses any grant; requests are simply left pending.
// Ports: req (N requests), ptr (start index), allow -> gnt_valid, gnt_idx.
module sdfm_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          allow,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    always_comb begin
        // Rotate so that bit 0 of rot is the request at ptr.
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];

        // Lowest set bit of the rotated vector; scanning downward leaves the lowest.
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end

        // Rotate back, wrapping modulo N for non-power-of-two channel counts.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end

        gnt_valid = allow && (|req);
        gnt_idx   = sum[PW-1:0];
    end

endmodule

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO, register array, first-word fall-through head.
// Latency: push visible at head_dat one cycle after the push edge when empty.
// Backpressure: push is dropped when full unless a pop happens on the same edge; pop when empty is ignored.
// Ports: clr (sync clear), push_vld/push_dat, pop_vld -> head_dat, count, count_nxt, empty, full.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             empty,
    output logic             full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop_eff;
    logic          push_eff;

    assign pop_eff  = pop_vld && (count != '0);
    assign push_eff = push_vld && ((count != CNT_W'(DEPTH)) || pop_eff);

    always_comb begin
        count_nxt = count;
        case ({push_eff, pop_eff})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally; count is kept separately so full and empty stay unambiguous.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_eff) begin
                mem[wptr] <= push_dat;
                wptr      <= wptr + AW'(1);
            end
            if (pop_eff) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    assign head_dat = mem[rptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sdfm_result_fifo.sv
// Purpose: collects per-channel filter results, round-robin tags them into one shared FIFO.
// Latency: update pulse to FIFO head in 2 cycles uncontended, up to CH_NUM+1 under contention.
// Backpressure: none toward filters; when full, samples wait in holding registers and newer ones overrun.
// Ports: SYSCLK, SYSRSTn, bus (slave modport: captures/controls in, head/status/events out).
module sdfm_result_fifo
    import sdfm_pkg::*;
#(
    parameter  int CH_NUM = 4,
    parameter  int DATA_W = SDFM_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int TAG_W  = tag_width(CH_NUM),
    localparam int CNT_W  = clog2(DEPTH) + 1
) (
    input  logic               SYSCLK,
    input  logic               SYSRSTn,
    sdfm_result_fifo_if.slave  bus
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              flush_now;
    logic [CH_NUM-1:0] capture;
    logic [CH_NUM-1:0] pending;
    logic [CH_NUM-1:0] granted;
    logic [DATA_W-1:0] hold [CH_NUM];
    logic [TAG_W-1:0]  rr_ptr;
    logic              gnt_vld;
    logic [TAG_W-1:0]  gnt_idx;
    logic              arb_allow;
    entry_t            push_ent;
    entry_t            head_ent;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              lvl_hit;
    logic              levelup;
    logic [CH_NUM-1:0] overrun;

    // Disabling the block behaves as a flush held every cycle.
    assign flush_now = bus.flush_signal || !bus.en_reg;
    assign capture   = bus.update_signalx & bus.ch_en_regx & {CH_NUM{bus.en_reg}};

    // A full FIFO can still accept a write on the edge that pops its head.
    assign arb_allow = !flush_now && (!fifo_full || bus.rd_signal);

    sdfm_rr_arb #(.N(CH_NUM)) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .allow     (arb_allow),
        .gnt_valid (gnt_vld),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        granted = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            granted[i] = gnt_vld && (gnt_idx == TAG_W'(i));
        end
    end

    always_comb begin
        push_ent.tag  = gnt_idx;
        push_ent.data = hold[gnt_idx];
    end

    // A capture on a granted channel refills its holding register after the old value
    // leaves, so only an ungranted, still-pending channel loses a sample.
    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            pending <= '0;
            overrun <= '0;
            rr_ptr  <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                hold[i] <= '0;
            end
        end else if (flush_now) begin
            pending <= '0;
            overrun <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (capture[i]) begin
                    hold[i]    <= bus.data_inx[DATA_W*i +: DATA_W];
                    pending[i] <= 1'b1;
                    overrun[i] <= pending[i] && !granted[i];
                end else begin
                    overrun[i] <= 1'b0;
                    if (granted[i]) begin
                        pending[i] <= 1'b0;
                    end
                end
            end
            if (gnt_vld) begin
                if (gnt_idx == TAG_W'(CH_NUM - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= gnt_idx + TAG_W'(1);
                end
            end
        end
    end

    sync_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk  (SYSCLK),
        .arst_n    (SYSRSTn),
        .clr       (flush_now),
        .push_vld  (gnt_vld),
        .push_dat  (push_ent),
        .pop_vld   (bus.rd_signal),
        .head_dat  (head_ent),
        .count     (count),
        .count_nxt (count_nxt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Edge-triggered on the upward crossing only, so a level held at or above the
    // threshold does not re-fire until the fill has dropped below it.
    assign lvl_hit = (bus.level_reg != '0) && (count < bus.level_reg) && (count_nxt >= bus.level_reg);

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            levelup <= 1'b0;
        end else begin
            levelup <= lvl_hit && !flush_now;
        end
    end

    assign bus.rd_data         = head_ent.data;
    assign bus.rd_tag          = head_ent.tag;
    assign bus.count           = count;
    assign bus.empty           = fifo_empty;
    assign bus.full            = fifo_full;
    assign bus.levelup_signal  = levelup;
    assign bus.overrun_signalx = overrun;

endmodule

// File: tb/tb_sdfm_result_fifo.sv
// Purpose: directed scoreboard bench for sdfm_result_fifo (4 channels, 32-bit data, 16 entries).
// Latency: n/a.
// Backpressure: n/a.
module tb_sdfm_result_fifo;

    localparam int CH    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TW    = 2;

    logic SYSCLK  = 1'b0;
    logic SYSRSTn = 1'b0;

    always #5 SYSCLK = ~SYSCLK;

    sdfm_result_fifo_if #(.CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

    sdfm_result_fifo #(.CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .SYSCLK  (SYSCLK),
        .SYSRSTn (SYSRSTn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int lvl_cnt  = 0;
    logic [TW+DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic set_upd(input int ch, input logic [DW-1:0] d);
        bus.update_signalx[ch]       = 1'b1;
        bus.data_inx[ch*DW +: DW]    = d;
    endtask

    task automatic clr_upd();
        bus.update_signalx = '0;
    endtask

    task automatic expect_push(input logic [TW-1:0] tag, input logic [DW-1:0] d);
        exp_q.push_back({tag, d});
    endtask

    task automatic drain(input int n);
        bus.rd_signal = 1'b1;
        repeat (n) tick();
        bus.rd_signal = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},   64'(bus.count),           64'h0);
        chk({tag, "_empty"},   64'(bus.empty),           64'h1);
        chk({tag, "_full"},    64'(bus.full),            64'h0);
        chk({tag, "_rd_data"}, 64'(bus.rd_data),         64'h0);
        chk({tag, "_rd_tag"},  64'(bus.rd_tag),          64'h0);
        chk({tag, "_levelup"}, 64'(bus.levelup_signal),  64'h0);
        chk({tag, "_overrun"}, 64'(bus.overrun_signalx), 64'h0);
    endtask

    // Monitor: every accepted pop is checked against the scoreboard head.
    initial begin
        logic [TW+DW-1:0] e;
        forever begin
            @(negedge SYSCLK);
            if (SYSRSTn && bus.rd_signal && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop: DUT popped tag %0d data 0x%0h, scoreboard empty",
                             bus.rd_tag, bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_head", 64'({bus.rd_tag, bus.rd_data}), 64'(e));
                end
            end
            if (SYSRSTn && bus.levelup_signal) begin
                lvl_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lvl_base;

        bus.en_reg         = 1'b1;
        bus.ch_en_regx     = '1;
        bus.update_signalx = '0;
        bus.data_inx       = '0;
        bus.flush_signal   = 1'b0;
        bus.rd_signal      = 1'b0;
        bus.level_reg      = '0;

        // Reset values
        #12;
        chk_reset_state("rst");
        SYSRSTn = 1'b1;
        tick();

        // Single update on ch2
        set_upd(2, 32'h1234_5678);
        expect_push(2'd2, 32'h1234_5678);
        tick();
        clr_upd();
        chk("single_lat1_empty", 64'(bus.empty), 64'h1);
        tick();
        chk("single_empty",  64'(bus.empty),   64'h0);
        chk("single_count",  64'(bus.count),   64'h1);
        chk("single_tag",    64'(bus.rd_tag),  64'h2);
        chk("single_data",   64'(bus.rd_data), 64'h1234_5678);
        drain(1);
        chk("single_drained", 64'(bus.empty), 64'h1);

        // Contention from rr_ptr=0 (flush resets the pointer)
        bus.flush_signal = 1'b1;
        tick();
        bus.flush_signal = 1'b0;
        for (int c = 0; c < CH; c++) begin
            set_upd(c, 32'hA0 + 32'(c));
            expect_push(TW'(c), 32'hA0 + 32'(c));
        end
        tick();
        clr_upd();
        repeat (4) tick();
        chk("rr0_count", 64'(bus.count), 64'h4);
        drain(4);
        chk("rr0_drained", 64'(bus.empty), 64'h1);

        // Grant ch1 to move rr_ptr to 2, then contend again: order 2,3,0,1
        set_upd(1, 32'hB1);
        expect_push(2'd1, 32'hB1);
        tick();
        clr_upd();
        tick();
        for (int c = 0; c < CH; c++) begin
            set_upd(c, 32'hC0 + 32'(c));
        end
        expect_push(2'd2, 32'hC2);
        expect_push(2'd3, 32'hC3);
        expect_push(2'd0, 32'hC0);
        expect_push(2'd1, 32'hC1);
        tick();
        clr_upd();
        repeat (4) tick();
        chk("rr2_count", 64'(bus.count), 64'h5);
        drain(5);
        chk("rr2_drained", 64'(bus.empty), 64'h1);

        // Fill to full with back-to-back ch0 updates
        for (int k = 0; k < DEPTH; k++) begin
            set_upd(0, 32'h100 + 32'(k));
            expect_push(2'd0, 32'h100 + 32'(k));
            tick();
        end
        clr_upd();
        tick();
        chk("full_count", 64'(bus.count), 64'h10);
        chk("full_flag",  64'(bus.full),  64'h1);
        set_upd(1, 32'h1);
        tick();
        clr_upd();
        chk("ovr_first_none", 64'(bus.overrun_signalx), 64'h0);
        set_upd(1, 32'h2);
        expect_push(2'd1, 32'h2);
        tick();
        clr_upd();
        chk("ovr_pulse", 64'(bus.overrun_signalx), 64'h2);
        tick();
        chk("ovr_once",       64'(bus.overrun_signalx), 64'h0);
        chk("ovr_count_kept", 64'(bus.count),           64'h10);
        chk("ovr_full_kept",  64'(bus.full),            64'h1);
        drain(1);
        chk("pushpop1_count", 64'(bus.count), 64'h10);
        set_upd(0, 32'h55);
        expect_push(2'd0, 32'h55);
        tick();
        clr_upd();
        chk("full_wait_no_ovr", 64'(bus.overrun_signalx), 64'h0);
        drain(1);
        chk("pushpop2_count", 64'(bus.count), 64'h10);
        chk("pushpop2_full",  64'(bus.full),  64'h1);
        chk("pushpop2_head",  64'({bus.rd_tag, bus.rd_data}), 64'h0000_0000_0000_0102);
        drain(DEPTH);
        chk("full_drained_empty", 64'(bus.empty), 64'h1);
        chk("full_drained_count", 64'(bus.count), 64'h0);

        // Level-up at threshold 4
        bus.level_reg = 5'd4;
        for (int k = 0; k < 4; k++) begin
            set_upd(0, 32'h200 + 32'(k));
            expect_push(2'd0, 32'h200 + 32'(k));
            tick();
            chk("lvl_below", 64'(bus.levelup_signal), 64'h0);
        end
        clr_upd();
        tick();
        chk("lvl_hit_count", 64'(bus.count),          64'h4);
        chk("lvl_hit",       64'(bus.levelup_signal), 64'h1);
        tick();
        chk("lvl_one_cycle", 64'(bus.levelup_signal), 64'h0);
        drain(1);
        chk("lvl_pop_count", 64'(bus.count),          64'h3);
        chk("lvl_pop_quiet", 64'(bus.levelup_signal), 64'h0);
        set_upd(2, 32'h300);
        expect_push(2'd2, 32'h300);
        tick();
        clr_upd();
        tick();
        chk("lvl_rehit_count", 64'(bus.count),          64'h4);
        chk("lvl_rehit",       64'(bus.levelup_signal), 64'h1);
        drain(4);

        // Threshold 0 never fires
        bus.level_reg = '0;
        lvl_base = lvl_cnt;
        for (int k = 0; k < 4; k++) begin
            set_upd(0, 32'h250 + 32'(k));
            expect_push(2'd0, 32'h250 + 32'(k));
            tick();
        end
        clr_upd();
        tick();
        tick();
        chk("lvl0_count",  64'(bus.count),        64'h4);
        chk("lvl0_pulses", 64'(lvl_cnt - lvl_base), 64'h0);
        drain(4);

        // Flush with 5 stored and 2 pending
        for (int k = 0; k < 5; k++) begin
            set_upd(0, 32'h400 + 32'(k));
            tick();
        end
        clr_upd();
        tick();
        chk("flush_pre_count", 64'(bus.count), 64'h5);
        set_upd(1, 32'h501);
        set_upd(3, 32'h503);
        tick();
        clr_upd();
        bus.flush_signal = 1'b1;
        tick();
        bus.flush_signal = 1'b0;
        exp_q.delete();
        chk("flush_count", 64'(bus.count), 64'h0);
        chk("flush_empty", 64'(bus.empty), 64'h1);
        repeat (3) tick();
        chk("flush_no_late_write", 64'(bus.count), 64'h0);
        drain(1);
        chk("pop_empty_ignored", 64'(bus.count), 64'h0);

        // Disabled channel does not capture
        bus.ch_en_regx = 4'b0111;
        set_upd(3, 32'h600);
        tick();
        clr_upd();
        repeat (2) tick();
        chk("ch_dis_count", 64'(bus.count), 64'h0);
        bus.ch_en_regx = '1;

        // Asynchronous reset mid-burst
        bus.level_reg = 5'd2;
        for (int k = 0; k < 3; k++) begin
            set_upd(0, 32'h700 + 32'(k));
            set_upd(1, 32'h780 + 32'(k));
            tick();
        end
        #2;
        SYSRSTn = 1'b0;
        #1;
        clr_upd();
        exp_q.delete();
        chk_reset_state("arst");
        #3;
        SYSRSTn = 1'b1;
        bus.level_reg = '0;
        tick();

        // Recovery after reset
        set_upd(3, 32'h7777);
        expect_push(2'd3, 32'h7777);
        tick();
        clr_upd();
        tick();
        chk("post_rst_count", 64'(bus.count), 64'h1);
        drain(1);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
